// File: rtl/sopc_system_linux_cpu_oci_dct_seq.sv
// Direct-branch trace code packer: accumulates 3-bit codes into a 30-bit word and hands it downstream.
// Optional saturating dropped-code counter enabled by macro DCT_OVERFLOW_CNT_EN.
module sopc_system_linux_cpu_oci_dct_seq #(
    parameter int MAX_CODES = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       trace_en,
    input  logic                       code_valid,
    input  logic [2:0]                 code,
    input  logic                       flush_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3*MAX_CODES-1:0]     out_data,
    output logic [3:0]                 out_count,
    output logic [3*MAX_CODES-1:0]     dct_buffer,
    output logic [3:0]                 dct_count,
    output logic [7:0]                 overflow_cnt
);

    localparam int         W       = 3 * MAX_CODES;
    localparam logic [3:0] MAX_CNT = 4'(MAX_CODES);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic           pending, pending_nxt;
    logic [W-1:0]   buf_nxt, post_buf, data_nxt;
    logic [3:0]     cnt_nxt, post_cnt, ocnt_nxt;
    logic           capture, free, flush_any, load;

    assign out_valid = (state == HOLD);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        capture  = code_valid && trace_en && (dct_count != MAX_CNT);
        post_buf = dct_buffer;
        post_cnt = dct_count;
        if (capture) begin
            post_buf[3*int'(dct_count) +: 3] = code;
            post_cnt = dct_count + 4'd1;
        end

        free      = !out_valid || out_ready;
        flush_any = flush_req || pending;
        load      = free && ((post_cnt == MAX_CNT) || (flush_any && (post_cnt != 4'd0)));

        state_nxt = state;
        unique case (state)
            ACCUM: if (load) state_nxt = HOLD;
            HOLD:  if (out_ready && !load) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase

        // A flush seen while the output is busy waits; once free it is either served or moot.
        pending_nxt = free ? 1'b0 : (pending || flush_req);

        buf_nxt  = load ? '0 : post_buf;
        cnt_nxt  = load ? 4'd0 : post_cnt;
        data_nxt = load ? post_buf : out_data;
        ocnt_nxt = load ? post_cnt : out_count;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ACCUM;
            pending    <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= 4'd0;
            out_data   <= '0;
            out_count  <= 4'd0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            dct_buffer <= buf_nxt;
            dct_count  <= cnt_nxt;
            out_data   <= data_nxt;
            out_count  <= ocnt_nxt;
        end
    end

`ifdef DCT_OVERFLOW_CNT_EN
    logic       drop;
    logic [7:0] ovf_q;

    // Codes are only refused when the buffer is full and waiting on the output register.
    assign drop = code_valid && trace_en && (dct_count == MAX_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf_q <= 8'd0;
        else if (drop && (ovf_q != 8'hFF))
            ovf_q <= ovf_q + 8'd1;
    end

    assign overflow_cnt = ovf_q;
`else
    assign overflow_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sopc_system_linux_cpu_oci_dct_seq.sv
// Directed bench for the trace code packer: full words, flushes, back-pressure, pending flush, reset.
module tb_sopc_system_linux_cpu_oci_dct_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_en;
    logic        code_valid;
    logic [2:0]  code;
    logic        flush_req;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  overflow_cnt;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DCT_OVERFLOW_CNT_EN
    localparam logic [7:0] OVF_AFTER_25 = 8'd5;
`else
    localparam logic [7:0] OVF_AFTER_25 = 8'd0;
`endif

    sopc_system_linux_cpu_oci_dct_seq #(.MAX_CODES(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_en     (trace_en),
        .code_valid   (code_valid),
        .code         (code),
        .flush_req    (flush_req),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [2:0] c);
        code_valid = 1'b1;
        code       = c;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    initial begin
        logic [2:0] seq [10];
        seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

        reset_n    = 1'b0;
        trace_en   = 1'b0;
        code_valid = 1'b0;
        code       = 3'd0;
        flush_req  = 1'b0;
        out_ready  = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_dct_buf",   32'(dct_buffer), 32'd0);
        check("rst_dct_cnt",   32'(dct_count), 32'd0);
        check("rst_ovf",       32'(overflow_cnt), 32'd0);
        reset_n = 1'b1;
        tick();

        // Ten codes 0..7,0,1 with the sink always ready.
        trace_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_code(seq[i]);
            if (i == 1) check("buf_after_2", 32'(dct_buffer), 32'o10);
            if (i == 8) check("cnt_after_9", 32'(dct_count), 32'd9);
            if (i == 8) check("no_word_at_9", 32'(out_valid), 32'd0);
        end
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_data",  32'(out_data), 32'o1076543210);
        check("full_count", 32'(out_count), 32'd10);
        check("full_dct_cnt", 32'(dct_count), 32'd0);
        check("full_dct_buf", 32'(dct_buffer), 32'd0);
        tick();
        check("full_one_cycle", 32'(out_valid), 32'd0);

        // Partial word via flush.
        send_code(3'd5);
        send_code(3'd2);
        send_code(3'd7);
        check("part_no_word", 32'(out_valid), 32'd0);
        flush();
        check("flush_valid", 32'(out_valid), 32'd1);
        check("flush_count", 32'(out_count), 32'd3);
        check("flush_data",  32'(out_data), 32'o725);
        tick();
        check("flush_drop_valid", 32'(out_valid), 32'd0);

        // Flush with an empty buffer produces nothing.
        flush();
        check("empty_flush", 32'(out_valid), 32'd0);

        // Code and flush in the same cycle emit the word including that code.
        send_code(3'd3);
        code_valid = 1'b1;
        code       = 3'd6;
        flush_req  = 1'b1;
        tick();
        code_valid = 1'b0;
        flush_req  = 1'b0;
        check("same_cyc_valid", 32'(out_valid), 32'd1);
        check("same_cyc_count", 32'(out_count), 32'd2);
        check("same_cyc_data",  32'(out_data), 32'o63);
        tick();

        // Disabled capture, and retention across trace_en deassertion.
        trace_en = 1'b0;
        send_code(3'd4);
        check("en_off_cnt", 32'(dct_count), 32'd0);
        trace_en = 1'b1;
        send_code(3'd1);
        send_code(3'd2);
        trace_en = 1'b0;
        tick();
        tick();
        check("retain_cnt", 32'(dct_count), 32'd2);
        check("retain_buf", 32'(dct_buffer), 32'o21);
        flush();
        check("retain_flush_cnt", 32'(out_count), 32'd2);
        tick();
        trace_en = 1'b1;

        // Back-pressure: 25 codes with the sink stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 25; i++) send_code(3'(i % 8));
        check("bp_valid",    32'(out_valid), 32'd1);
        check("bp_data1",    32'(out_data), 32'o1076543210);
        check("bp_count1",   32'(out_count), 32'd10);
        check("bp_dct_cnt",  32'(dct_count), 32'd10);
        check("bp_dct_buf",  32'(dct_buffer), 32'o3210765432);
        check("bp_ovf",      32'(overflow_cnt), 32'(OVF_AFTER_25));
        tick();
        check("bp_stable_data", 32'(out_data), 32'o1076543210);
        out_ready = 1'b1;
        tick();
        check("bp_b2b_valid", 32'(out_valid), 32'd1);
        check("bp_data2",     32'(out_data), 32'o3210765432);
        check("bp_dct_cnt2",  32'(dct_count), 32'd0);
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Flush while holding: served on the handshake.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_code(3'd1);
        for (int i = 4; i < 8; i++) send_code(3'(i));
        flush();
        check("pf_still_held", 32'(out_count), 32'd10);
        check("pf_dct_cnt",    32'(dct_count), 32'd4);
        out_ready = 1'b1;
        tick();
        check("pf_valid", 32'(out_valid), 32'd1);
        check("pf_count", 32'(out_count), 32'd4);
        check("pf_data",  32'(out_data), 32'o7654);
        check("pf_dct_cnt_clr", 32'(dct_count), 32'd0);
        tick();
        check("pf_drain", 32'(out_valid), 32'd0);

        // Reset mid-operation: held word and partial buffer are discarded.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_code(3'd2);
        for (int i = 0; i < 6; i++) send_code(3'd3);
        check("mr_pre_cnt", 32'(dct_count), 32'd6);
        #3;
        reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_data",  32'(out_data), 32'd0);
        check("mr_count", 32'(out_count), 32'd0);
        check("mr_buf",   32'(dct_buffer), 32'd0);
        check("mr_cnt",   32'(dct_count), 32'd0);
        check("mr_ovf",   32'(overflow_cnt), 32'd0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        flush();
        check("mr_flush_none", 32'(out_valid), 32'd0);
        tick();
        check("mr_still_none", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
